// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding for the instruction-memory boot loader.
// Optional checksum stage is controlled by IMEM_LOADER_CHECKSUM_EN (see imem_loader.sv).
package imem_loader_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_INIT  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CSUM  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_RUN   = 3'd4,
      ST_ERROR = 3'd5
   } state_t;

endpackage

// File: rtl/imem_loader_checksum.sv
// load_checksum: running modulo-2**DATA_W sum of program words, compared
// against the trailing checksum word. Only instantiated when
// IMEM_LOADER_CHECKSUM_EN is defined.
module load_checksum
   import imem_loader_pkg::*;
#(
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              add,
   input  logic [DATA_W-1:0] add_data,
   input  logic [DATA_W-1:0] cmp_data,
   output logic              match_c
);

   logic [DATA_W-1:0] acc;

   // Accumulator: cleared at the start of every load, sums each written word
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (add) begin
         acc <= acc + add_data;
      end
   end

   assign match_c = (acc == cmp_data);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: holds the CPU in reset while a valid/ready word stream is
// written to instruction memory from address 0, then releases the CPU after
// a short hold. Re-triggerable with reload from RUN or ERROR.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum word.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned DEPTH    = 256,
   parameter int unsigned HOLD_CYC = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              reload,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_reset,
   output logic              load_done,
   output logic              load_error,
   output logic [ADDR_W:0]   word_count
);

   localparam int unsigned CNT_W     = ADDR_W + 1;
   localparam int unsigned HOLD_W    = $clog2(HOLD_CYC + 1);
   localparam int unsigned LAST_ADDR = DEPTH - 1;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] addr;
   logic [HOLD_W-1:0] hold_cnt;
   logic              accept;
   logic              at_end;

   assign accept = in_valid & in_ready;
   assign at_end = (addr == ADDR_W'(LAST_ADDR));

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic csum_ok;

   load_checksum #(
      .DATA_W (DATA_W)
   ) u_csum (
      .clk      (clk),
      .reset    (reset),
      .clear    (state == ST_INIT),
      .add      (accept && (state == ST_LOAD)),
      .add_data (in_data),
      .cmp_data (in_data),
      .match_c  (csum_ok)
   );
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_INIT;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         ST_INIT: state_next = ST_LOAD;
         ST_LOAD: begin
            if (accept) begin
               if (in_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_next = ST_CSUM;
`else
                  state_next = ST_HOLD;
`endif
               end else if (at_end) begin
                  state_next = ST_ERROR;
               end
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CSUM: begin
            if (accept) begin
               state_next = csum_ok ? ST_HOLD : ST_ERROR;
            end
         end
`endif
         ST_HOLD: begin
            if (hold_cnt == '0) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN, ST_ERROR: begin
            if (reload) begin
               state_next = ST_INIT;
            end
         end
         default: state_next = ST_INIT;
      endcase
   end

   // Output decode; memory write is combinational from the handshake
   always_comb begin
      in_ready   = 1'b0;
      cpu_reset  = 1'b1;
      load_done  = 1'b0;
      load_error = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = addr;
      mem_wdata  = '0;
      case (state)
         ST_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               mem_we    = 1'b1;
               mem_wdata = in_data;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CSUM: in_ready = 1'b1;
`endif
         ST_RUN: begin
            cpu_reset = 1'b0;
            load_done = 1'b1;
         end
         ST_ERROR: load_error = 1'b1;
         default: ;
      endcase
   end

   // Address / word counter; address saturates at the last usable word
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr       <= '0;
         word_count <= '0;
      end else if (state == ST_INIT) begin
         addr       <= '0;
         word_count <= '0;
      end else if ((state == ST_LOAD) && accept) begin
         word_count <= word_count + CNT_W'(1);
         if (!at_end) begin
            addr <= addr + ADDR_W'(1);
         end
      end
   end

   // Hold counter: the entry cycle of HOLD sees HOLD_CYC, then it counts
   // HOLD_CYC-1 down to 0, giving HOLD_CYC+1 cycles in HOLD
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_cnt <= HOLD_W'(HOLD_CYC);
      end else if (state != ST_HOLD) begin
         hold_cnt <= HOLD_W'(HOLD_CYC);
      end else if (hold_cnt != '0) begin
         hold_cnt <= hold_cnt - HOLD_W'(1);
      end
   end

endmodule
